// File: rtl/bsg_ruche_pkg.sv
// Shared ruche link definitions.
//   bsg_ruche_link_s        : one beat on a ruche wire (valid + payload).
//   ruche_ready_latency_gp  : cycles between ready leaving the sink and the
//                             upstream reacting to it.
package bsg_ruche_pkg;

    localparam int ruche_ready_latency_gp = 1;

    typedef struct packed {
        logic        v;
        logic [31:0] data;
    } bsg_ruche_link_s;

endpackage

// File: rtl/bsg_mem_1r1w.sv
// One-write, one-read storage array with asynchronous read.
//   w_clk_i   : write clock
//   w_v_i     : write enable
//   w_addr_i  : write address
//   w_data_i  : write data
//   r_addr_i  : read address
//   r_data_o  : read data, combinational from r_addr_i
// Contents are not reset.
module bsg_mem_1r1w #(
    parameter int width_p                = 8,
    parameter int els_p                  = 4,
    parameter int read_write_same_addr_p = 0,
    localparam int addr_width_lp         = (els_p > 1) ? $clog2(els_p) : 1
) (
    input  logic                     w_clk_i,
    input  logic                     w_v_i,
    input  logic [addr_width_lp-1:0] w_addr_i,
    input  logic [width_p-1:0]       w_data_i,
    input  logic [addr_width_lp-1:0] r_addr_i,
    output logic [width_p-1:0]       r_data_o
);

    logic [width_p-1:0] mem [els_p];

    always_ff @(posedge w_clk_i) begin
        if (w_v_i) mem[w_addr_i] <= w_data_i;
    end

    // With same-address forwarding enabled a read sees the beat being written
    // this cycle; otherwise it sees the value stored before the edge.
    generate
        if (read_write_same_addr_p != 0) begin : g_fwd
            assign r_data_o = (w_v_i && (w_addr_i == r_addr_i)) ? w_data_i : mem[r_addr_i];
        end else begin : g_nofwd
            assign r_data_o = mem[r_addr_i];
        end
    endgenerate

endmodule

// File: rtl/bsg_ruche_link_sink_fifo.sv
// Receive-side elastic buffer at the end of a ruche link.
//   clk_i, reset_i : clock, asynchronous active-high reset
//   v_i, data_i    : incoming link beat (positive polarity)
//   ready_o        : registered ready returned upstream; a beat may be sent
//                    in cycle t only if ready_o was 1 in cycle t-1
//   v_o, data_o    : head entry, zero-latency (async read)
//   yumi_i         : consumer dequeues the head
//   overflow_o     : sticky, set when a beat arrived with the FIFO full
module bsg_ruche_link_sink_fifo
    import bsg_ruche_pkg::*;
#(
    parameter int width_p = 8,
    parameter int els_p   = 4
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               yumi_i,
    output logic               overflow_o
);

    localparam int ptr_width_lp   = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int count_width_lp = $clog2(els_p + 1);

    // Ready must leave room for the beat already in flight plus one beat sent
    // on a stale ready, so it drops once occupancy would exceed els_p-2.
    localparam logic [count_width_lp-1:0] ready_thresh_lp =
        count_width_lp'(els_p - 1 - ruche_ready_latency_gp);
    localparam logic [ptr_width_lp-1:0]   ptr_last_lp = ptr_width_lp'(els_p - 1);
    localparam logic [count_width_lp-1:0] count_full_lp = count_width_lp'(els_p);

    logic [ptr_width_lp-1:0]   rptr_r, wptr_r, rptr_next, wptr_next;
    logic [count_width_lp-1:0] count_r, count_next;
    logic                      ready_r, overflow_r, ready_d1_r;
    logic                      full, enq, deq, drop;

    assign v_o        = (count_r != '0);
    assign full       = (count_r == count_full_lp);
    assign deq        = yumi_i & v_o;
    // Writes ignore ready_o; only a full FIFO with no same-cycle dequeue drops.
    assign enq        = v_i & (~full | deq);
    assign drop       = v_i & full & ~deq;
    assign ready_o    = ready_r;
    assign overflow_o = overflow_r;

    // Explicit wrap so non-power-of-two depths work.
    assign rptr_next = !deq ? rptr_r : (rptr_r == ptr_last_lp) ? '0 : rptr_r + ptr_width_lp'(1);
    assign wptr_next = !enq ? wptr_r : (wptr_r == ptr_last_lp) ? '0 : wptr_r + ptr_width_lp'(1);

    always_comb begin
        count_next = count_r;
        if (enq && !deq)      count_next = count_r + count_width_lp'(1);
        else if (!enq && deq) count_next = count_r - count_width_lp'(1);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            rptr_r     <= '0;
            wptr_r     <= '0;
            count_r    <= '0;
            ready_r    <= 1'b1;
            overflow_r <= 1'b0;
        end else begin
            rptr_r     <= rptr_next;
            wptr_r     <= wptr_next;
            count_r    <= count_next;
            ready_r    <= (count_next <= ready_thresh_lp);
            overflow_r <= overflow_r | drop;
        end
    end

    bsg_mem_1r1w #(
        .width_p               (width_p),
        .els_p                 (els_p),
        .read_write_same_addr_p(0)
    ) mem (
        .w_clk_i (clk_i),
        .w_v_i   (enq),
        .w_addr_i(wptr_r),
        .w_data_i(data_i),
        .r_addr_i(rptr_r),
        .r_data_o(data_o)
    );

    // Ready as seen by the upstream in the previous cycle, for protocol checks.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) ready_d1_r <= 1'b1;
        else         ready_d1_r <= ready_r;
    end

    always @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!yumi_i || v_o)
                else $error("bsg_ruche_link_sink_fifo: yumi_i asserted with v_o low");
            assert (!(v_i && !ready_d1_r))
                else $warning("bsg_ruche_link_sink_fifo: protocol violation, v_i while prior ready_o was low");
        end
    end

endmodule

// File: tb/tb_bsg_ruche_link_sink_fifo.sv
module tb_bsg_ruche_link_sink_fifo;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    // depth-4 instance
    logic       v_i = 1'b0, yumi_i = 1'b0;
    logic [7:0] data_i = '0;
    logic       ready, v_o, ovf;
    logic [7:0] data_o;

    // depth-3 instance for wrap test
    logic       b_v_i = 1'b0, b_yumi_i = 1'b0;
    logic [7:0] b_data_i = '0;
    logic       b_ready, b_v_o, b_ovf;
    logic [7:0] b_data_o;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bsg_ruche_link_sink_fifo #(.width_p(8), .els_p(4)) dut (
        .clk_i(clk), .reset_i(rst), .v_i(v_i), .data_i(data_i), .ready_o(ready),
        .v_o(v_o), .data_o(data_o), .yumi_i(yumi_i), .overflow_o(ovf)
    );

    bsg_ruche_link_sink_fifo #(.width_p(8), .els_p(3)) dut3 (
        .clk_i(clk), .reset_i(rst), .v_i(b_v_i), .data_i(b_data_i), .ready_o(b_ready),
        .v_o(b_v_o), .data_o(b_data_o), .yumi_i(b_yumi_i), .overflow_o(b_ovf)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++; if (ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", ready); end
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL reset_v_o got=%b exp=0", v_o); end
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
        checks++; if (b_v_o !== 1'b0) begin failures++; $display("FAIL reset_b_v_o got=%b exp=0", b_v_o); end
        tick(); tick();
        rst = 1'b0;
        tick();
        checks++; if (ready !== 1'b1 || v_o !== 1'b0) begin failures++; $display("FAIL idle ready=%b v_o=%b exp 1/0", ready, v_o); end
    endtask

    task automatic test_burst();
        logic [7:0] exp_d [3];
        exp_d[0] = 8'hA0; exp_d[1] = 8'hA1; exp_d[2] = 8'hA2;
        for (int i = 0; i < 3; i++) begin
            checks++; if (ready !== 1'b1) begin failures++; $display("FAIL burst_ready_%0d got=%b exp=1", i, ready); end
            v_i = 1'b1; data_i = exp_d[i];
            tick();
            if (i == 0) begin
                checks++; if (v_o !== 1'b1 || data_o !== 8'hA0) begin failures++; $display("FAIL burst_latency v_o=%b data=%h exp 1/a0", v_o, data_o); end
            end
        end
        v_i = 1'b0;
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL burst_ready_fall got=%b exp=0", ready); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (v_o !== 1'b1 || data_o !== exp_d[i]) begin failures++; $display("FAIL burst_pop_%0d v_o=%b data=%h exp=%h", i, v_o, data_o, exp_d[i]); end
            yumi_i = 1'b1;
            tick();
            if (i == 0) begin
                checks++; if (ready !== 1'b1) begin failures++; $display("FAIL burst_ready_rise got=%b exp=1", ready); end
            end
        end
        yumi_i = 1'b0;
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL burst_empty v_o=%b exp=0", v_o); end
    endtask

    task automatic test_stale_ready();
        // fourth beat is sent on a ready that was still 1 the cycle before
        for (int i = 0; i < 4; i++) begin
            v_i = 1'b1; data_i = 8'hB0 + 8'(i);
            tick();
        end
        v_i = 1'b0;
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL stale_ovf got=%b exp=0", ovf); end
        checks++; if (ready !== 1'b0) begin failures++; $display("FAIL stale_ready got=%b exp=0", ready); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (v_o !== 1'b1 || data_o !== 8'hB0 + 8'(i)) begin failures++; $display("FAIL stale_pop_%0d v_o=%b data=%h exp=%h", i, v_o, data_o, 8'hB0 + 8'(i)); end
            yumi_i = 1'b1;
            tick();
        end
        yumi_i = 1'b0;
        checks++; if (v_o !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL stale_drained v_o=%b ready=%b exp 0/1", v_o, ready); end
    endtask

    task automatic test_stream();
        int bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (i > 0) begin
                if (v_o !== 1'b1 || data_o !== 8'(i - 1) || ready !== 1'b1) begin
                    bad++;
                    $display("FAIL stream_%0d v_o=%b data=%h ready=%b exp 1/%h/1", i, v_o, data_o, ready, 8'(i - 1));
                end
            end
            v_i = 1'b1; data_i = 8'(i);
            yumi_i = (i > 0);
            tick();
        end
        checks++; if (bad != 0) failures++;
        v_i = 1'b0;
        checks++; if (v_o !== 1'b1 || data_o !== 8'd99) begin failures++; $display("FAIL stream_last v_o=%b data=%h exp 1/63", v_o, data_o); end
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        checks++; if (v_o !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL stream_end v_o=%b ready=%b exp 0/1", v_o, ready); end
    endtask

    task automatic test_wrap();
        logic [7:0] q[$];
        int pushed = 0, popped = 0, cyc = 0;
        logic enq, deq;
        while (popped < 10 && cyc < 300) begin
            deq = (q.size() != 0) && ($urandom_range(0, 1) == 1);
            enq = (pushed < 10) && ($urandom_range(0, 2) != 0) && (q.size() < 3 || deq);
            checks++; if (b_v_o !== (q.size() != 0)) begin failures++; $display("FAIL wrap_v_o cyc=%0d got=%b exp=%b", cyc, b_v_o, q.size() != 0); end
            if (deq) begin
                checks++; if (b_data_o !== q[0]) begin failures++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", cyc, b_data_o, q[0]); end
            end
            b_v_i = enq; b_data_i = 8'h50 + 8'(pushed); b_yumi_i = deq;
            tick();
            if (deq) begin void'(q.pop_front()); popped++; end
            if (enq) begin q.push_back(8'h50 + 8'(pushed)); pushed++; end
            cyc++;
        end
        b_v_i = 1'b0; b_yumi_i = 1'b0;
        checks++; if (popped != 10) begin failures++; $display("FAIL wrap_timeout popped=%0d exp=10", popped); end
        checks++; if (b_ovf !== 1'b0 || b_v_o !== 1'b0) begin failures++; $display("FAIL wrap_end ovf=%b v_o=%b exp 0/0", b_ovf, b_v_o); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 6; i++) begin
            v_i = 1'b1; data_i = 8'hC0 + 8'(i);
            tick();
            checks++;
            if (ovf !== (i >= 4)) begin failures++; $display("FAIL ovf_beat_%0d got=%b exp=%b", i, ovf, i >= 4); end
        end
        v_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++; if (v_o !== 1'b1 || data_o !== 8'hC0 + 8'(i)) begin failures++; $display("FAIL ovf_pop_%0d v_o=%b data=%h exp=%h", i, v_o, data_o, 8'hC0 + 8'(i)); end
            yumi_i = 1'b1;
            tick();
        end
        yumi_i = 1'b0;
        checks++; if (v_o !== 1'b0 || ovf !== 1'b1) begin failures++; $display("FAIL ovf_hold v_o=%b ovf=%b exp 0/1", v_o, ovf); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%b exp=0", ovf); end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            v_i = 1'b1; data_i = 8'hD0 + 8'(i);
            tick();
        end
        v_i = 1'b0;
        checks++; if (v_o !== 1'b1 || ready !== 1'b0) begin failures++; $display("FAIL mid_pre v_o=%b ready=%b exp 1/0", v_o, ready); end
        #2 rst = 1'b1;
        #1;
        checks++; if (v_o !== 1'b0 || ready !== 1'b1) begin failures++; $display("FAIL mid_async v_o=%b ready=%b exp 0/1", v_o, ready); end
        tick();
        rst = 1'b0;
        v_i = 1'b1; data_i = 8'hE0;
        tick();
        v_i = 1'b0;
        checks++; if (v_o !== 1'b1 || data_o !== 8'hE0) begin failures++; $display("FAIL mid_ptrs v_o=%b data=%h exp 1/e0", v_o, data_o); end
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        checks++; if (v_o !== 1'b0) begin failures++; $display("FAIL mid_drain v_o=%b exp=0", v_o); end
    endtask

    initial begin
        test_reset();
        test_burst();
        test_stale_ready();
        test_stream();
        test_wrap();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
